// File: rtl/p2s_slave_pkg.sv
// Shared definitions for the p2s serial status link: FSM state encodings and the
// counter-width helper, also used by s2p_master users.
package p2s_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clogb2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/p2s_slave_sync_edge.sv
// Synchronizer for one asynchronous input with level, rise and fall outputs.
// Edges are detected against one extra registered copy of the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/p2s_slave.sv
// Far end of the serial status link: snapshots pi while sld_n is low, then shifts it
// out LSB-first on so, one bit per falling edge of the master's sclk.
module p2s_slave
  import p2s_slave_pkg::*;
#(
  parameter int   NBIT        = 64,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LVL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBIT-1:0] pi,
  input  logic            sclk,
  input  logic            sld_n,
  output logic            so,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_err,
  output logic [1:0]      dbg_state
);

  localparam int            CW   = clogb2(NBIT);
  localparam logic [CW-1:0] LAST = CW'(NBIT - 1);

  // Handshake: there is no valid/ready pair on this link. The master owns timing;
  // sld_n low means "load", each sclk fall advances one bit, and the master samples
  // so on sclk rise, so so must be stable for a full half-period before each rise.

  logic sclk_s, sclk_rise, sclk_fall;
  logic sld_n_s, sld_rise, sld_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .d     (sclk),
    .level (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sld (
    .clk   (clk),
    .rst   (rst),
    .d     (sld_n),
    .level (sld_n_s),
    .rise  (sld_rise),
    .fall  (sld_fall)
  );

  // Only the sclk fall and the sld_n level drive the FSM.
  logic edges_unused;
  assign edges_unused = ^{sclk_s, sclk_rise, sld_rise, sld_fall};

  state_t          state, state_n;
  logic [CW-1:0]   bit_cnt, bit_cnt_n;
  logic [NBIT-1:0] sh, sh_n;
  logic            so_n, busy_n, done_n, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      so         <= IDLE_LVL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      sh         <= sh_n;
      so         <= so_n;
      busy       <= busy_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    so_n      = so;
    done_n    = 1'b0;
    err_n     = 1'b0;
    if (!sld_n_s) begin
      // Load beats a simultaneous sclk fall; resampled every clk while low.
      sh_n      = pi;
      so_n      = pi[0];
      bit_cnt_n = '0;
      state_n   = ST_LOAD;
      if (state == ST_SHIFT) begin
        if (bit_cnt == LAST) done_n = 1'b1;
        else                 err_n  = 1'b1;
      end
    end else begin
      case (state)
        ST_LOAD:  state_n = ST_SHIFT;
        ST_SHIFT: begin
          if (sclk_fall) begin
            if (bit_cnt != LAST) begin
              sh_n      = sh >> 1;
              so_n      = sh[1];
              bit_cnt_n = bit_cnt + 1'b1;
            end else begin
              state_n = ST_OVER;
              so_n    = IDLE_LVL;
              err_n   = 1'b1;
            end
          end
        end
        default: state_n = state;
      endcase
    end
    busy_n = (state_n == ST_SHIFT);
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_p2s_slave.sv
// Directed bench for p2s_slave with NBIT=8, SYNC_STAGES=2 and a master model
// running 8 clk per sclk half-period.
module tb_p2s_slave;
  import p2s_slave_pkg::*;

  localparam int NBIT = 8;
  localparam int H    = 8;

  logic            clk = 1'b0;
  logic            rst, sclk, sld_n;
  logic [NBIT-1:0] pi;
  logic            so, busy, frame_done, frame_err;
  logic [1:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  p2s_slave #(.NBIT(NBIT), .SYNC_STAGES(2), .IDLE_LVL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .pi         (pi),
    .sclk       (sclk),
    .sld_n      (sld_n),
    .so         (so),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Each high sample counts, so a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_frame();
    sld_n = 1'b0;
    wait_clks(H);
    sld_n = 1'b1;
    wait_clks(H);
  endtask

  // nrise rising edges with falls between them; the last fall coincides with sld_n
  // going low (same_edge) or follows it. Ends with the next frame loaded.
  task automatic master_frame(input int nrise, input bit same_edge,
                              input logic [NBIT-1:0] mid_pi, output logic [NBIT-1:0] word);
    word = '0;
    for (int k = 0; k < nrise; k++) begin
      sclk = 1'b1;
      word[k] = so;
      if (k == 3) pi = mid_pi;
      wait_clks(H);
      if (k < nrise - 1) begin
        sclk = 1'b0;
        wait_clks(H);
      end
    end
    if (same_edge) begin
      sclk  = 1'b0;
      sld_n = 1'b0;
    end else begin
      sld_n = 1'b0;
      wait_clks(H / 2);
      sclk = 1'b0;
    end
    wait_clks(H);
    sld_n = 1'b1;
    wait_clks(H);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; sld_n = 1'b1; pi = '0;
    wait_clks(3);
    n_vec++; if (so !== 1'b0)         begin n_err++; $display("FAIL reset_so: got %b want 0", so); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_vec++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_err: got %b want 0", frame_err); end
    rst = 1'b0;
    wait_clks(4);
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_full_frame();
    logic [NBIT-1:0] w;
    int d0, e0;
    pi = 8'hA5;
    d0 = done_cnt; e0 = err_cnt;
    open_frame();
    n_vec++; if (busy !== 1'b1)          begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
    n_vec++; if (dbg_state !== ST_SHIFT) begin n_err++; $display("FAIL full_state: got %0d want %0d", dbg_state, ST_SHIFT); end
    n_vec++; if (so !== 1'b1)            begin n_err++; $display("FAIL full_bit0: got %b want 1", so); end
    master_frame(8, 1'b0, 8'hA5, w);
    n_vec++; if (w !== 8'hA5)            begin n_err++; $display("FAIL full_word: got %h want a5", w); end
    n_vec++; if (done_cnt - d0 !== 1)    begin n_err++; $display("FAIL full_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (err_cnt - e0 !== 0)     begin n_err++; $display("FAIL full_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_pi_change();
    logic [NBIT-1:0] w;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    master_frame(8, 1'b0, 8'h3C, w);
    n_vec++; if (w !== 8'hA5) begin n_err++; $display("FAIL pichg_first: got %h want a5", w); end
    master_frame(8, 1'b0, 8'h3C, w);
    n_vec++; if (w !== 8'h3C) begin n_err++; $display("FAIL pichg_next: got %h want 3c", w); end
    n_vec++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL pichg_done: got %0d want 2", done_cnt - d0); end
    n_vec++; if (err_cnt - e0 !== 0)  begin n_err++; $display("FAIL pichg_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_short_frame();
    logic [NBIT-1:0] w;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    master_frame(5, 1'b0, 8'h3C, w);
    n_vec++; if (w[4:0] !== 5'b11100) begin n_err++; $display("FAIL short_bits: got %b want 11100", w[4:0]); end
    n_vec++; if (err_cnt - e0 !== 1)  begin n_err++; $display("FAIL short_err: got %0d want 1", err_cnt - e0); end
    n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL short_done: got %0d want 0", done_cnt - d0); end
    master_frame(8, 1'b0, 8'h3C, w);
    n_vec++; if (w !== 8'h3C)         begin n_err++; $display("FAIL short_next: got %h want 3c", w); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL short_next_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    logic [NBIT-1:0] w;
    int d0, e0;
    pi = 8'hC3;
    open_frame();
    d0 = done_cnt; e0 = err_cnt;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      sclk = 1'b1;
      if (k < 8) w[k] = so;
      wait_clks(H);
      sclk = 1'b0;
      wait_clks(H);
    end
    n_vec++; if (w !== 8'hC3)           begin n_err++; $display("FAIL ovr_word: got %h want c3", w); end
    n_vec++; if (err_cnt - e0 !== 1)    begin n_err++; $display("FAIL ovr_err: got %0d want 1", err_cnt - e0); end
    n_vec++; if (so !== 1'b0)           begin n_err++; $display("FAIL ovr_so: got %b want 0", so); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL ovr_busy: got %b want 0", busy); end
    n_vec++; if (dbg_state !== ST_OVER) begin n_err++; $display("FAIL ovr_state: got %0d want %0d", dbg_state, ST_OVER); end
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1; wait_clks(H);
      sclk = 1'b0; wait_clks(H);
    end
    n_vec++; if (err_cnt - e0 !== 1)    begin n_err++; $display("FAIL ovr_ignore_err: got %0d want 1", err_cnt - e0); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL ovr_ignore_busy: got %b want 0", busy); end
    open_frame();
    master_frame(8, 1'b0, 8'hC3, w);
    n_vec++; if (w !== 8'hC3)           begin n_err++; $display("FAIL ovr_next: got %h want c3", w); end
    n_vec++; if (done_cnt - d0 !== 1)   begin n_err++; $display("FAIL ovr_next_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (err_cnt - e0 !== 1)    begin n_err++; $display("FAIL ovr_next_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [NBIT-1:0] w;
    int d0, e0;
    pi = 8'h96;
    open_frame();
    d0 = done_cnt; e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1;
      wait_clks(H);
      if (k < 3) begin
        sclk = 1'b0;
        wait_clks(H);
      end
    end
    rst = 1'b1;
    wait_clks(1);
    n_vec++; if (so !== 1'b0)           begin n_err++; $display("FAIL rstmid_so: got %b want 0", so); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
    wait_clks(2);
    rst = 1'b0;
    sclk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_clks(H); sclk = 1'b1;
      wait_clks(H); sclk = 1'b0;
    end
    wait_clks(H);
    n_vec++; if (busy !== 1'b0 || so !== 1'b0) begin n_err++; $display("FAIL rstmid_ignore: got busy=%b so=%b want 0 0", busy, so); end
    n_vec++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      n_err++; $display("FAIL rstmid_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    open_frame();
    n_vec++; if (busy !== 1'b1)         begin n_err++; $display("FAIL rstmid_reload_busy: got %b want 1", busy); end
    master_frame(8, 1'b0, 8'h96, w);
    n_vec++; if (w !== 8'h96)           begin n_err++; $display("FAIL rstmid_next: got %h want 96", w); end
    n_vec++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++; $display("FAIL rstmid_next_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [NBIT-1:0] w;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    master_frame(8, 1'b1, 8'h5B, w);
    n_vec++; if (w !== 8'h96)         begin n_err++; $display("FAIL b2b_first: got %h want 96", w); end
    n_vec++; if (so !== 1'b1)         begin n_err++; $display("FAIL b2b_load_so: got %b want 1", so); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL b2b_done1: got %0d want 1", done_cnt - d0); end
    master_frame(8, 1'b1, 8'h5B, w);
    n_vec++; if (w !== 8'h5B)         begin n_err++; $display("FAIL b2b_second: got %h want 5b", w); end
    n_vec++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done2: got %0d want 2", done_cnt - d0); end
    n_vec++; if (err_cnt - e0 !== 0)  begin n_err++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pi_change();
    test_short_frame();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
